// File: rtl/recirc_pkg.sv
// Shared definitions for the recirculation router: state encoding and default
// parameter values used by recirc_router and recirc_lane.
package recirc_pkg;

  localparam int unsigned DEF_N         = 4;
  localparam int unsigned DEF_W         = 8;
  localparam int unsigned DEF_IDLE_SYNC = 2;
  localparam int unsigned DEF_CW        = 8;

  typedef enum logic {
    ST_RECIRC = 1'b0,
    ST_FWD    = 1'b1
  } state_e;

endpackage

// File: rtl/recirc_lane.sv
// One lane of the router: registered forward/recirculation outputs and, when
// RECIRC_CNT_EN is defined, a saturating count of valid recirculated words.
module recirc_lane
  import recirc_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk_f,
  input  logic          reset_L,
  input  state_e        mode_i,
`ifdef RECIRC_CNT_EN
  input  logic          clr_cnt_i,
  output logic [CW-1:0] cnt_o,
`endif
  input  logic [W-1:0]  data_i,
  input  logic          valid_i,
  output logic [W-1:0]  data_out_o,
  output logic          valid_out_o,
  output logic [W-1:0]  data_rec_o,
  output logic          valid_rec_o
);

  logic [W-1:0] fwd_data_q, rec_data_q;
  logic         fwd_valid_q, rec_valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, whatever the statement order.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      fwd_data_q  <= '0;
      fwd_valid_q <= 1'b0;
      rec_data_q  <= '0;
      rec_valid_q <= 1'b0;
    end else if (mode_i == ST_FWD) begin
      fwd_data_q  <= data_i;
      fwd_valid_q <= valid_i;
      rec_data_q  <= '0;
      rec_valid_q <= 1'b0;
    end else begin
      fwd_data_q  <= '0;
      fwd_valid_q <= 1'b0;
      rec_data_q  <= data_i;
      rec_valid_q <= valid_i;
    end
  end

  assign data_out_o  = fwd_data_q;
  assign valid_out_o = fwd_valid_q;
  assign data_rec_o  = rec_data_q;
  assign valid_rec_o = rec_valid_q;

`ifdef RECIRC_CNT_EN
  logic [CW-1:0] cnt_q;

  // The toggle-edge clear wins over the increment for the word still recirculated.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q <= '0;
    end else if (clr_cnt_i) begin
      cnt_q <= '0;
    end else if (mode_i == ST_RECIRC && valid_i && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/recirc_router.sv
// N-lane router sending words to recirculation until downstream idle is seen
// stably. Optional per-lane recirculation counters under macro RECIRC_CNT_EN.
module recirc_router
  import recirc_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned W         = DEF_W,
  parameter int unsigned IDLE_SYNC = DEF_IDLE_SYNC,
  parameter int unsigned CW        = DEF_CW
) (
  input  logic            clk_f,
  input  logic            reset_L,
  input  logic [N*W-1:0]  data_in,
  input  logic [N-1:0]    valid_in,
  input  logic            idle_in,
  output logic [N*W-1:0]  data_out,
  output logic [N-1:0]    valid_out,
  output logic [N*W-1:0]  data_rec,
  output logic [N-1:0]    valid_rec,
`ifdef RECIRC_CNT_EN
  output logic [N*CW-1:0] recirc_cnt,
`endif
  output logic            fwd_mode
);

  localparam int unsigned CNT_W = $clog2(IDLE_SYNC + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               toggle;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    idle_cnt_d = '0;
    toggle     = 1'b0;
    // RECIRC waits for idle_in=1, FORWARD waits for idle_in=0.
    if (idle_in == (state_q == ST_RECIRC)) begin
      if (idle_cnt_q == CNT_W'(IDLE_SYNC - 1)) begin
        toggle = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_RECIRC;
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      if (toggle) begin
        state_q <= (state_q == ST_RECIRC) ? ST_FWD : ST_RECIRC;
      end
    end
  end

  assign fwd_mode = (state_q == ST_FWD);

  for (genvar i = 0; i < N; i++) begin : g_lane
    recirc_lane #(
      .W  (W),
      .CW (CW)
    ) u_lane (
      .clk_f       (clk_f),
      .reset_L     (reset_L),
      .mode_i      (state_q),
`ifdef RECIRC_CNT_EN
      .clr_cnt_i   (toggle && state_q == ST_RECIRC),
      .cnt_o       (recirc_cnt[i*CW +: CW]),
`endif
      .data_i      (data_in[i*W +: W]),
      .valid_i     (valid_in[i]),
      .data_out_o  (data_out[i*W +: W]),
      .valid_out_o (valid_out[i]),
      .data_rec_o  (data_rec[i*W +: W]),
      .valid_rec_o (valid_rec[i])
    );
  end

endmodule

// File: doc/recirc_router.md
Name: recirc_router

Overview:
- Parametrised, registered router for N lanes of W-bit data with per-lane valid.
- Successor to the fixed 4x8 demux recirculation stage.
- While downstream is not idle, every input word is sent back on the recirculation path. Once downstream idle has been seen stably, words go to the forward (demux) path.
- Adds idle debouncing with hysteresis, a visible mode flag and optional per-lane recirculation counters.

Parameters:
- N, 4, number of lanes (>=1).
- W, 8, data width per lane (>=1).
- IDLE_SYNC, 2, consecutive cycles idle_in must hold a new level before mode changes (>=1).
- CW, 8, width of each recirculation counter (used only with the optional feature).

Ports:
- clk_f  in  1  sole clock; all state updates on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- data_in  in  N*W  lane i occupies bits [i*W +: W].
- valid_in  in  N  lane i valid.
- idle_in  in  1  downstream idle indication (IDLE_OUT).
- data_out  out  N*W  forward path data, registered.
- valid_out  out  N  forward path valid, registered.
- data_rec  out  N*W  recirculation path data, registered.
- valid_rec  out  N  recirculation path valid, registered.
- fwd_mode  out  1  1 = FORWARD state, 0 = RECIRC state.
- recirc_cnt  out  N*CW  per-lane count; present only with RECIRC_CNT_EN.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - All outputs 0; state RECIRC; debounce counter 0.
  - Outputs stay 0 while reset is held.
  - The first edge after release behaves as a normal cycle.
- States:
  - RECIRC (reset state): the target level is idle_in=1.
  - FORWARD: the target level is idle_in=0.
- Debounce:
  - idle_cnt, width $clog2(IDLE_SYNC+1).
  - Each edge: if idle_in equals the target level, idle_cnt increments; otherwise idle_cnt clears to 0.
  - When idle_cnt would reach IDLE_SYNC, the state toggles and idle_cnt clears on that same edge.
  - With IDLE_SYNC=1, the mode toggles on the first edge at which idle_in shows the target level.
- Routing, 1-cycle latency, lanes independent:
  - At each edge, the route uses the state value before that edge (the pre-update state).
  - Routed path: data <= data_in, valid <= valid_in.
  - Other path: valid <= 0, data <= 0.
  - Data is copied even when its valid bit is 0. Consumers qualify data by valid only.
- Mode-change timing:
  - The word sampled on the toggling edge still goes to the old path.
  - Words from the next edge onward go to the new path. No word is dropped or duplicated.
- fwd_mode is the registered state and changes on the toggling edge.
- Simultaneous idle_in glitch and toggle: the debounce counter is the only arbiter. A glitch shorter than IDLE_SYNC never toggles the mode.
- Reset mid-FORWARD: the block returns immediately to RECIRC and 0 outputs. Any in-flight word is discarded.

Optional Feature:
- Macro RECIRC_CNT_EN.
- Defined:
  - Per-lane CW-bit counter increments on each edge where lane i is routed to recirculation with valid_in[i]=1.
  - Saturates at 2^CW-1; no wrap.
  - Cleared by reset and on the RECIRC->FORWARD toggle edge.
  - Holds its value in FORWARD.
  - Driven on recirc_cnt.
- Undefined: recirc_cnt port and counters are absent; all other behaviour is identical.

Decomposition:
- Package recirc_pkg holds:
  - state encoding constants ST_RECIRC=1'b0, ST_FWD=1'b1;
  - default values for N, W, IDLE_SYNC, CW.
- One sub-module, recirc_lane: the per-lane output registers, routing mux and optional counter, generated N times.
- The top level holds the debounce counter and the FSM.

Test Plan (N=4, W=8, IDLE_SYNC=2 unless stated):
- Reset: hold reset_L=0 with data_in=ffeeddcc and valid_in=4'hf -> all outputs 0 and fwd_mode=0. On the first edge after release, data_rec=ffeeddcc, valid_rec=4'hf, valid_out=0.
- Recirculation loop:
  - Feed data_rec/valid_rec back to the inputs with idle_in=0 for 5 cycles -> same word repeats on rec path each cycle; valid_out stays 0.
  - With RECIRC_CNT_EN, each lane count = 5.
- Debounce reject: idle_in=1 for 1 cycle, then 0 -> fwd_mode stays 0; no forward traffic.
- Switch:
  - idle_in=1 held; data_in=bbaa9988, valid_in=4'hf present on the toggling edge -> word appears on rec path and fwd_mode=1 on that edge.
  - Next word data_in lane2=8'h77 with valid_in=4'b0100 -> valid_out=4'b0100, lane2 data_out=77, valid_rec=0.
- Return: in FORWARD, drive idle_in=0 for 2 cycles -> fwd_mode=0 on the 2nd edge; subsequent words are on rec path. With IDLE_SYNC=1, a 1-cycle drop is enough.
- Reset mid-FORWARD: assert reset_L=0 asynchronously between edges -> outputs go 0 immediately, fwd_mode=0, counters 0.
